clock_core_tz: RTL and testbench

Parametrised successor of the team's 50 MHz six-digit HH:MM:SS clock, placed between the board clock/switches/buttons and the six 7-segment displays. Adds debounced single-step button presses, selectable hour/minute setting, a 12/24-hour display mode with a PM indicator, and a compile-time time-zone offset. Time is kept in a single counter set with one writer, and all display outputs are registered.

---
 rtl/clock_core_tz.sv | 247 ++++++++++++++++++++++++
 tb/tb_clock_core_tz.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_core_tz.sv
// clock_core_tz: six-digit HH:MM:SS clock with debounced set buttons, 12/24-hour display
// and a compile-time time-zone offset on the displayed hour.
//
// Ports:
//   clk        system clock (single domain)
//   reset      asynchronous active-low reset, clears the whole block
//   sw         1 = set-time mode, 0 = run mode
//   field_sel  field adjusted in set mode: 0 = hours, 1 = minutes
//   mode_12h   1 = 12-hour display, 0 = 24-hour display
//   button1    increment button (asynchronous, bouncing)
//   button2    decrement button (asynchronous, bouncing)
//   seg0..seg5 active-low {g,f,e,d,c,b,a}; seg0/1 seconds, seg2/3 minutes, seg4/5 hours
//   pm         displayed hour is 12..23 while in 12-hour mode
//   sec_tick   one-cycle pulse per seconds increment, aligned with the updated display
//
// Configuration macro: CLOCK_CORE_TZ_EN. When defined, TZ_OFFSET_H is added to the displayed
// hour; when undefined the stored hour is displayed directly and no adder exists.
module clock_core_tz #(
  parameter int unsigned CLK_HZ          = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TZ_OFFSET_H     = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sw,
  input  logic       field_sel,
  input  logic       mode_12h,
  input  logic       button1,
  input  logic       button2,
  output logic [6:0] seg0,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic [6:0] seg3,
  output logic [6:0] seg4,
  output logic [6:0] seg5,
  output logic       pm,
  output logic       sec_tick
);

  localparam int unsigned PW = $clog2(CLK_HZ);
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(CLK_HZ - 1);
  localparam logic [DW-1:0] DebMax   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [6:0]    Blank    = 7'h7F;

  if (CLK_HZ < 2) begin : g_bad_clk_hz
    $error("CLK_HZ must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (TZ_OFFSET_H > 23) begin : g_bad_tz
    $error("TZ_OFFSET_H must be in 0..23");
  end

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = Blank;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] tens_of(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] ones_of(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  // ---------------------------------------------------------------------------------------
  // Button synchronisers and debouncers; index 0 = button1 (up), 1 = button2 (down)
  // ---------------------------------------------------------------------------------------
  logic [1:0]    btn;
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    db_q, db_d;
  logic [1:0]    press_q, press_d;
  logic [DW-1:0] cnt_q [2];
  logic [DW-1:0] cnt_d [2];

  assign btn = {button2, button1};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      db_d[i]    = db_q[i];
      press_d[i] = 1'b0;
      cnt_d[i]   = '0;
      // Count only while the synchronised level disagrees; any agreement restarts the count.
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DebMax) begin
          db_d[i]    = sync2_q[i];
          press_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      press_q  <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      sync1_q  <= btn;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      press_q  <= press_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  // ---------------------------------------------------------------------------------------
  // Prescaler and time counters (single writer for seconds/minutes/hours)
  // ---------------------------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hour_q, hour_d;
  logic          sw_q;
  logic          tick, tick_q;
  logic          up, dn;

  assign up = press_q[0];
  assign dn = press_q[1];

  always_comb begin
    tick    = !sw && (presc_q == PrescMax);
    presc_d = (sw || tick) ? '0 : presc_q + PW'(1);
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    if (sw) begin
      // A tick coincident with entering set mode is dropped by the !sw gate above.
      if (!sw_q) sec_d = '0;
      if (up ^ dn) begin
        if (!field_sel) begin
          if (up) hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
          else    hour_d = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
        end else begin
          if (up) min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
          else    min_d = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
        end
      end
    end else if (tick) begin
      if (sec_q == 6'd59) begin
        sec_d = '0;
        if (min_q == 6'd59) begin
          min_d  = '0;
          hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      sw_q    <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      sw_q    <= sw;
      tick_q  <= tick;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Display hour, 12-hour mapping and registered decode
  // ---------------------------------------------------------------------------------------
  logic [4:0] hd, h12, hour_disp;
  logic [3:0] hr_tens;
  logic [6:0] seg0_d, seg1_d, seg2_d, seg3_d, seg4_d, seg5_d;
  logic       pm_d;

`ifdef CLOCK_CORE_TZ_EN
  logic [5:0] hd_sum;
  assign hd_sum = {1'b0, hour_q} + 6'(TZ_OFFSET_H);
  assign hd     = (hd_sum >= 6'd24) ? 5'(hd_sum - 6'd24) : hd_sum[4:0];
`else
  assign hd = hour_q;
`endif

  always_comb begin
    h12 = (hd >= 5'd12) ? hd - 5'd12 : hd;
    if (h12 == 5'd0) h12 = 5'd12;
    hour_disp = mode_12h ? h12 : hd;
    hr_tens   = tens_of({1'b0, hour_disp});
    seg0_d    = seg_dec(ones_of(sec_q));
    seg1_d    = seg_dec(tens_of(sec_q));
    seg2_d    = seg_dec(ones_of(min_q));
    seg3_d    = seg_dec(tens_of(min_q));
    seg4_d    = seg_dec(ones_of({1'b0, hour_disp}));
    seg5_d    = (mode_12h && (hr_tens == 4'd0)) ? Blank : seg_dec(hr_tens);
    pm_d      = mode_12h && (hd >= 5'd12);
  end

  // sec_tick is delayed one stage so it lands in the same cycle as the new seconds digits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg0     <= Blank;
      seg1     <= Blank;
      seg2     <= Blank;
      seg3     <= Blank;
      seg4     <= Blank;
      seg5     <= Blank;
      pm       <= 1'b0;
      sec_tick <= 1'b0;
    end else begin
      seg0     <= seg0_d;
      seg1     <= seg1_d;
      seg2     <= seg2_d;
      seg3     <= seg3_d;
      seg4     <= seg4_d;
      seg5     <= seg5_d;
      pm       <= pm_d;
      sec_tick <= tick_q;
    end
  end

endmodule

// File: tb/tb_clock_core_tz.sv
module tb_clock_core_tz;

  localparam int CLK_HZ = 10;
  localparam int DEB    = 4;
`ifdef CLOCK_CORE_TZ_EN
  localparam int TZ = 5;
  localparam logic [6:0] H0_ONES = 7'h12, H1_ONES = 7'h02, H2_ONES = 7'h78;
  localparam logic [6:0] H23_TENS = 7'h40, H23_ONES = 7'h19;
`else
  localparam int TZ = 0;
  localparam logic [6:0] H0_ONES = 7'h40, H1_ONES = 7'h79, H2_ONES = 7'h24;
  localparam logic [6:0] H23_TENS = 7'h24, H23_ONES = 7'h30;
`endif

  logic clk = 1'b0;
  logic reset, sw, field_sel, mode_12h, button1, button2;
  logic [6:0] seg0, seg1, seg2, seg3, seg4, seg5;
  logic pm, sec_tick;

  clock_core_tz #(
    .CLK_HZ(CLK_HZ),
    .DEBOUNCE_CYCLES(DEB),
    .TZ_OFFSET_H(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw(sw),
    .field_sel(field_sel),
    .mode_12h(mode_12h),
    .button1(button1),
    .button2(button2),
    .seg0(seg0),
    .seg1(seg1),
    .seg2(seg2),
    .seg3(seg3),
    .seg4(seg4),
    .seg5(seg5),
    .pm(pm),
    .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: time as seconds of day plus cycles since the last tick.
  int t_cnt, phase, disp_t;
  bit sw_prev, tick_prev, disp_mode, exp_tick, track;
  logic [6:0] pat [10];

  typedef struct {
    int         hours;
    bit         m12;
    logic [6:0] e5;
    logic [6:0] e4;
    bit         epm;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [42:0] model_disp(input int t, input bit m12);
    int h, mi, s, hd, dh;
    logic [6:0] s5;
    bit p;
    h  = t / 3600;
    mi = (t / 60) % 60;
    s  = t % 60;
    hd = (h + TZ) % 24;
    if (m12) begin
      dh = (hd % 12 == 0) ? 12 : hd % 12;
      p  = (hd >= 12);
    end else begin
      dh = hd;
      p  = 1'b0;
    end
    s5 = (m12 && dh / 10 == 0) ? 7'h7F : pat[dh / 10];
    return {s5, pat[dh % 10], pat[mi / 10], pat[mi % 10], pat[s / 10], pat[s % 10], p};
  endfunction

  function automatic logic [42:0] act_disp();
    return {seg5, seg4, seg3, seg2, seg1, seg0, pm};
  endfunction

  task automatic model_reset();
    t_cnt = 0; phase = 0; disp_t = 0;
    sw_prev = 1'b0; tick_prev = 1'b0;
  endtask

  task automatic model_adjust(input bit up, input bit fld);
    int h, m, s;
    h = t_cnt / 3600; m = (t_cnt / 60) % 60; s = t_cnt % 60;
    if (!fld) h = up ? (h + 1) % 24 : (h + 23) % 24;
    else      m = up ? (m + 1) % 60 : (m + 59) % 60;
    t_cnt = h * 3600 + m * 60 + s;
  endtask

  // One clock: advance the model at the edge, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    disp_t    = t_cnt;
    disp_mode = mode_12h;
    exp_tick  = tick_prev;
    tick_prev = 1'b0;
    if (sw) begin
      if (!sw_prev) t_cnt -= t_cnt % 60;
      phase = 0;
    end else begin
      phase++;
      if (phase == CLK_HZ) begin
        phase     = 0;
        t_cnt     = (t_cnt + 1) % 86400;
        tick_prev = 1'b1;
      end
    end
    sw_prev = sw;
    @(negedge clk);
    if (track) begin
      chk("display", act_disp(), model_disp(disp_t, disp_mode));
      chk("sec_tick", sec_tick, exp_tick);
    end
  endtask

  // Hold buttons for 'hold' cycles, release, let the debouncers settle.
  task automatic press(input bit up, input bit dn, input int hold);
    bit eff, was;
    eff = sw && (up ^ dn) && (hold >= DEB);
    was = track;
    if (sw) track = 1'b0;
    button1 = up; button2 = dn;
    repeat (hold) step();
    button1 = 1'b0; button2 = 1'b0;
    repeat (8) step();
    if (eff) model_adjust(up, field_sel);
    track = was;
  endtask

  task automatic set_field(input bit fld, input int target);
    int cur, md, diff;
    field_sel = fld;
    md = fld ? 60 : 24;
    for (int n = 0; n < 60; n++) begin
      cur = fld ? (t_cnt / 60) % 60 : t_cnt / 3600;
      if (cur == target) break;
      diff = (target - cur + md) % md;
      press(diff <= md / 2, diff > md / 2, 6);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int cyc, nt, r, op;
    bit seen;
    pat[0] = 7'h40; pat[1] = 7'h79; pat[2] = 7'h24; pat[3] = 7'h30; pat[4] = 7'h19;
    pat[5] = 7'h12; pat[6] = 7'h02; pat[7] = 7'h78; pat[8] = 7'h00; pat[9] = 7'h10;
`ifdef CLOCK_CORE_TZ_EN
    tbl[0] = '{7,  1'b1, 7'h79, 7'h24, 1'b1};
    tbl[1] = '{19, 1'b1, 7'h79, 7'h24, 1'b0};
    tbl[2] = '{4,  1'b1, 7'h7F, 7'h10, 1'b0};
    tbl[3] = '{4,  1'b0, 7'h40, 7'h10, 1'b0};
    tbl[4] = '{18, 1'b0, 7'h24, 7'h30, 1'b0};
    tbl[5] = '{20, 1'b1, 7'h7F, 7'h79, 1'b0};
    tbl[6] = '{10, 1'b1, 7'h7F, 7'h30, 1'b1};
`else
    tbl[0] = '{7,  1'b1, 7'h7F, 7'h78, 1'b0};
    tbl[1] = '{19, 1'b1, 7'h7F, 7'h78, 1'b1};
    tbl[2] = '{4,  1'b1, 7'h7F, 7'h19, 1'b0};
    tbl[3] = '{4,  1'b0, 7'h40, 7'h19, 1'b0};
    tbl[4] = '{18, 1'b0, 7'h79, 7'h00, 1'b0};
    tbl[5] = '{20, 1'b1, 7'h7F, 7'h00, 1'b1};
    tbl[6] = '{10, 1'b1, 7'h79, 7'h40, 1'b0};
`endif
    reset = 1'b0; sw = 1'b0; field_sel = 1'b0; mode_12h = 1'b0;
    button1 = 1'b0; button2 = 1'b0; track = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {act_disp(), sec_tick}, {{6{7'h7F}}, 2'b00});
    model_reset();
    reset = 1'b1;

    // Release display and first tick
    track = 1'b1;
    step();
    chk("release_display", act_disp(), {7'h40, H0_ONES, {4{7'h40}}, 1'b0});
    cyc = 1; seen = (sec_tick === 1'b1);
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      cyc++;
      seen = (sec_tick === 1'b1);
    end
    chk("first_tick_cycle", cyc, 11);
    chk("first_tick_seg0", seg0, 7'h79);

    // Rollover from 23:59:xx
    sw = 1'b1;
    repeat (2) step();
    set_field(0, 23);
    step();
    chk("hour_wrap_down", {seg5, seg4}, {H23_TENS, H23_ONES});
    set_field(1, 59);
    sw = 1'b0;
    nt = 0;
    repeat (601) begin
      step();
      if (sec_tick === 1'b1) nt++;
    end
    chk("rollover_ticks", nt, 60);
    chk("rollover_display", act_disp(), {7'h40, H0_ONES, {4{7'h40}}, 1'b0});

    // Minute wrap, coincident presses, bounce
    sw = 1'b1;
    step();
    set_field(1, 59);
    press(1'b1, 1'b0, 6);
    step();
    chk("min_wrap_up", {seg5, seg4, seg3, seg2}, {7'h40, H0_ONES, 7'h40, 7'h40});
    press(1'b1, 1'b1, 6);
    step();
    chk("both_buttons", {seg5, seg4, seg3, seg2}, {7'h40, H0_ONES, 7'h40, 7'h40});
    field_sel = 1'b0;
    press(1'b1, 1'b0, 3);
    step();
    chk("glitch_3", seg4, H0_ONES);
    press(1'b1, 1'b0, 5);
    step();
    chk("hold_5", seg4, H1_ONES);
    press(1'b1, 1'b0, 500);
    step();
    chk("hold_500", seg4, H2_ONES);

    // 12/24-hour table
    for (int v = 0; v < 7; v++) begin
      set_field(0, tbl[v].hours);
      mode_12h = tbl[v].m12;
      repeat (2) step();
      chk($sformatf("hour_table_%0d", v), {seg5, seg4, pm}, {tbl[v].e5, tbl[v].e4, tbl[v].epm});
    end
    mode_12h = 1'b0;

    // Randomized operations against the model
    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 3);
      case (op)
        0: begin
          sw = 1'($urandom_range(0, 1));
          repeat (2) step();
        end
        1: begin
          field_sel = 1'($urandom_range(0, 1));
          r = $urandom_range(0, 2);
          press(r != 1, r != 0, 6);
        end
        2: repeat ($urandom_range(1, 30)) step();
        default: begin
          mode_12h = 1'($urandom_range(0, 1));
          step();
        end
      endcase
    end

    // Reset mid-count with button1 held
    sw = 1'b0; mode_12h = 1'b0; field_sel = 1'b0;
    track = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b1;
    track = 1'b1;
    repeat (371) step();
    chk("seconds_37", {seg1, seg0}, {7'h30, 7'h78});
    button1 = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    sw = 1'b1;
    #1;
    chk("midreset_blank", act_disp(), {{6{7'h7F}}, 1'b0});
    track = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b1;
    step();
    chk("midreset_display", act_disp(), {7'h40, H0_ONES, {4{7'h40}}, 1'b0});
    repeat (6) step();
    chk("midreset_before_inc", seg4, H0_ONES);
    step();
    chk("midreset_inc", seg4, H1_ONES);
    button1 = 1'b0;
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
